// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch engine:
//   fetch_state_e    - fetch FSM state encoding (REQ / RESP / DRAIN)
//   INSTR_WIDTH      - width of one instruction word (32 bits)
//   READ_MEMORY_TAG  - bus request tag for a memory read:
//                      {read bit = 1, type = 4'b0001}. The top module
//                      zero-extends it to the bus tag width.
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_RESP  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam int INSTR_WIDTH = 32;

  localparam logic       TAG_READ_BIT      = 1'b1;
  localparam logic [3:0] TAG_TYPE_MEMORY   = 4'b0001;
  localparam int         READ_TAG_BITS     = 5;
  localparam logic [READ_TAG_BITS-1:0] READ_MEMORY_TAG = {TAG_READ_BIT, TAG_TYPE_MEMORY};

endpackage

// File: rtl/fetch_line_buf.sv
// ---------------------------------------------------------------------------
// fetch_line_buf
// Holds one cache line as LINE_BEATS rows of BUS_DATA_WIDTH bits.
//   clk      in   clock
//   wr_en    in   write one beat this cycle
//   wr_beat  in   beat slot to write
//   wr_data  in   beat data (little-endian: low bits = low address)
//   rd_addr  in   32-bit word index within the line for the NEXT cycle
//   rd_word  out  registered 32-bit word at rd_addr (one-cycle latency)
// A write to the row being read is forwarded, so the last beat of a fill
// can be presented as an instruction the very next cycle.
// ---------------------------------------------------------------------------
module fetch_line_buf
  import fetch_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int LINE_BEATS     = 8
) (
  input  logic                                            clk,
  input  logic                                            wr_en,
  input  logic [$clog2(LINE_BEATS)-1:0]                   wr_beat,
  input  logic [BUS_DATA_WIDTH-1:0]                       wr_data,
  input  logic [$clog2(LINE_BEATS*BUS_DATA_WIDTH/32)-1:0] rd_addr,
  output logic [INSTR_WIDTH-1:0]                          rd_word
);

  localparam int BEAT_W         = $clog2(LINE_BEATS);
  localparam int WORD_IDX_W     = $clog2(LINE_BEATS*BUS_DATA_WIDTH/32);
  localparam int WORDS_PER_BEAT = BUS_DATA_WIDTH / INSTR_WIDTH;
  localparam int SEL_SHIFT      = $clog2(WORDS_PER_BEAT);
  localparam int SEL_W          = (WORDS_PER_BEAT > 1) ? SEL_SHIFT : 1;

  logic [BUS_DATA_WIDTH-1:0] mem [LINE_BEATS];

  logic [BEAT_W-1:0]         rd_beat;
  logic [SEL_W-1:0]          rd_sel;
  logic [BUS_DATA_WIDTH-1:0] rd_row;
  logic [INSTR_WIDTH-1:0]    row_words [WORDS_PER_BEAT];
  logic [INSTR_WIDTH-1:0]    rd_word_d, rd_word_q;

  assign rd_beat = BEAT_W'(rd_addr >> SEL_SHIFT);
  assign rd_sel  = SEL_W'(rd_addr & WORD_IDX_W'(WORDS_PER_BEAT - 1));

  // Forward the beat being written when it is the row being read.
  assign rd_row = (wr_en && (wr_beat == rd_beat)) ? wr_data : mem[rd_beat];

  for (genvar gi = 0; gi < WORDS_PER_BEAT; gi++) begin : g_word_split
    assign row_words[gi] = rd_row[gi*INSTR_WIDTH +: INSTR_WIDTH];
  end

  always_comb begin
    rd_word_d = row_words[rd_sel];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_beat] <= wr_data;
    end
    rd_word_q <= rd_word_d;
  end

  assign rd_word = rd_word_q;

endmodule

// File: rtl/fetch_engine.sv
// ---------------------------------------------------------------------------
// fetch_engine
// Sequential instruction fetch: requests the line holding pc, collects
// LINE_BEATS response beats into a line buffer, then streams 32-bit
// instructions until pc leaves the line or a redirect arrives.
//   clk, reset                 clock, synchronous active-high reset
//   entry                      first fetch address (sampled during reset)
//   redirect_valid/_pc         one-cycle fetch redirect
//   bus_reqcyc/req/reqtag/ack  line read request (line-aligned address)
//   bus_respcyc/resp/resptag   response beats; bus_respack acknowledges
//   out_valid/ready/pc/instr   instruction stream
// ---------------------------------------------------------------------------
module fetch_engine
  import fetch_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  input  logic                      redirect_valid,
  input  logic [63:0]               redirect_pc,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [63:0]               out_pc,
  output logic [INSTR_WIDTH-1:0]    out_instr
);

  localparam int LINE_BYTES = LINE_BEATS * BUS_DATA_WIDTH / 8;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int BEAT_W     = $clog2(LINE_BEATS);

  fetch_state_e      state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              discard_q, discard_d;

  logic [63:0]       pc_plus4;
  logic [63:0]       line_addr;
  logic              last_beat;
  logic              leaves_line;
  logic              beat_accept;

  // Response tags are not matched: only one request is ever outstanding.
  logic unused_resptag;
  assign unused_resptag = ^bus_resptag;

  assign pc_plus4    = pc_q + 64'd4;
  assign line_addr   = {pc_q[63:OFF_W], {OFF_W{1'b0}}};
  assign last_beat   = (beat_cnt_q == BEAT_W'(LINE_BEATS - 1));
  assign leaves_line = (pc_plus4[OFF_W-1:0] == '0);
  assign beat_accept = (state_q == ST_RESP) && bus_respcyc && !reset;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    beat_cnt_d = beat_cnt_q;
    discard_d  = discard_q;
    case (state_q)
      ST_REQ: begin
        if (bus_reqack) begin
          state_d = ST_RESP;
        end
        // A redirect after the request was acked must still sink that fill.
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (bus_reqack) begin
            discard_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (redirect_valid) begin
          pc_d      = redirect_pc;
          discard_d = 1'b1;
        end
        if (bus_respcyc) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) begin
            state_d   = (discard_q || redirect_valid) ? ST_REQ : ST_DRAIN;
            discard_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        // Redirect wins over a same-cycle output handshake.
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = ST_REQ;
        end else if (out_ready) begin
          pc_d = pc_plus4;
          if (leaves_line) begin
            state_d = ST_REQ;
          end
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_REQ;
      pc_q       <= entry;
      beat_cnt_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      beat_cnt_q <= beat_cnt_d;
      discard_q  <= discard_d;
    end
  end

  // The buffer is addressed with next-cycle pc so the registered word lines
  // up with pc_q, including the cycle right after the final beat.
  fetch_line_buf #(
    .BUS_DATA_WIDTH (BUS_DATA_WIDTH),
    .LINE_BEATS     (LINE_BEATS)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (beat_accept),
    .wr_beat (beat_cnt_q),
    .wr_data (bus_resp),
    .rd_addr (pc_d[OFF_W-1:2]),
    .rd_word (out_instr)
  );

  if (BUS_DATA_WIDTH > 64) begin : g_req_wide
    assign bus_req = {{(BUS_DATA_WIDTH-64){1'b0}}, line_addr};
  end else if (BUS_DATA_WIDTH == 64) begin : g_req_exact
    assign bus_req = line_addr;
  end else begin : g_req_narrow
    assign bus_req = line_addr[BUS_DATA_WIDTH-1:0];
  end

  assign bus_reqtag  = {{(BUS_TAG_WIDTH-READ_TAG_BITS){1'b0}}, READ_MEMORY_TAG};
  assign bus_reqcyc  = (state_q == ST_REQ) && !reset;
  assign bus_respack = beat_accept;
  assign out_valid   = (state_q == ST_DRAIN) && !reset;
  assign out_pc      = pc_q;

endmodule

// File: tb/tb_fetch_engine.sv
// ---------------------------------------------------------------------------
// tb_fetch_engine
// Scoreboard bench: each fill pushes the instructions it should produce,
// and the drain loop pops and compares them as the engine hands them out.
// Inputs are driven just after the falling edge; outputs sampled 1ns later.
// ---------------------------------------------------------------------------
module tb_fetch_engine;

  localparam int BDW = 64;
  localparam int BTW = 13;
  localparam int LB  = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [63:0]    entry = 64'h0;
  logic           redirect_valid = 1'b0;
  logic [63:0]    redirect_pc = 64'h0;
  logic           bus_reqcyc;
  logic [BDW-1:0] bus_req;
  logic [BTW-1:0] bus_reqtag;
  logic           bus_reqack = 1'b0;
  logic           bus_respcyc = 1'b0;
  logic [BDW-1:0] bus_resp = '0;
  logic [BTW-1:0] bus_resptag = '0;
  logic           bus_respack;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [63:0]    out_pc;
  logic [31:0]    out_instr;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_engine #(
    .BUS_DATA_WIDTH (BDW),
    .BUS_TAG_WIDTH  (BTW),
    .LINE_BEATS     (LB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .entry          (entry),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus_reqcyc     (bus_reqcyc),
    .bus_req        (bus_req),
    .bus_reqtag     (bus_reqtag),
    .bus_reqack     (bus_reqack),
    .bus_respcyc    (bus_respcyc),
    .bus_resp       (bus_resp),
    .bus_resptag    (bus_resptag),
    .bus_respack    (bus_respack),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, required $finish");
    $fatal(1);
  end

  // Memory model: line 0x1000 uses the repeated-nibble pattern, every
  // other line holds an address-derived word at each 4-byte slot.
  function automatic logic [31:0] word_of(input logic [63:0] a);
    return (a[31:0] & 32'hFFFF_FFFC) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [63:0] beat_data(input logic [63:0] line, input int k);
    logic [3:0]  nib;
    logic [63:0] a;
    if (line == 64'h1000) begin
      nib = 4'(k + 1);
      return {16{nib}};
    end
    a = line + 64'(8 * k);
    return {word_of(a + 64'd4), word_of(a)};
  endfunction

  function automatic logic [31:0] exp_instr(input logic [63:0] pc);
    logic [3:0] nib;
    if ((pc & ~64'h3F) == 64'h1000) begin
      nib = 4'(pc[5:3]) + 4'd1;
      return {8{nib}};
    end
    return word_of(pc);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Holds reset for two cycles (with a response beat offered to prove it is
  // not acknowledged), then releases it and expects an immediate request.
  task automatic do_reset(input logic [63:0] e);
    reset       = 1'b1;
    entry       = e;
    bus_respcyc = 1'b1;
    #1;
    check_eq("rst_reqcyc", bus_reqcyc, 1'b0);
    check_eq("rst_respack", bus_respack, 1'b0);
    check_eq("rst_valid", out_valid, 1'b0);
    @(negedge clk);
    #1;
    check_eq("rst_respack2", bus_respack, 1'b0);
    @(negedge clk);
    bus_respcyc = 1'b0;
    reset       = 1'b0;
    #1;
    check_eq("post_rst_reqcyc", bus_reqcyc, 1'b1);
    check_eq("post_rst_req", bus_req, e & ~64'h3F);
    $display("txn reset entry=%h", e);
  endtask

  task automatic do_req(input logic [63:0] exp_addr, input int delay);
    int t = 0;
    while (bus_reqcyc !== 1'b1 && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    check_eq("req_cyc", bus_reqcyc, 1'b1);
    check_eq("req_addr", bus_req, exp_addr);
    check_eq("req_tag", bus_reqtag, 13'h11);
    check_eq("req_valid", out_valid, 1'b0);
    for (int i = 0; i < delay; i++) begin
      bus_respcyc = 1'b1;
      bus_resp    = 64'hDEAD_BEEF_DEAD_BEEF;
      #1;
      check_eq("early_respack", bus_respack, 1'b0);
      @(negedge clk);
      bus_respcyc = 1'b0;
      #1;
      check_eq("req_hold_cyc", bus_reqcyc, 1'b1);
      check_eq("req_hold_addr", bus_req, exp_addr);
    end
    $display("txn req addr=%h ack_delay=%0d", bus_req, delay);
    bus_reqack = 1'b1;
    @(negedge clk);
    bus_reqack = 1'b0;
    #1;
  endtask

  // Drives the 8 beats of a line (one idle gap before beat 2). Optionally
  // redirects on beat redir_beat or resets on beat rst_beat. When push is
  // set, the expected instructions from start_pc to the line end are queued.
  task automatic do_fill(input logic [63:0] line, input logic [63:0] start_pc,
                         input bit push, input int redir_beat, input logic [63:0] redir_to,
                         input int rst_beat, input logic [63:0] rst_entry);
    exp_t e;
    for (int k = 0; k < LB; k++) begin
      if (k == 2) begin
        bus_respcyc = 1'b0;
        #1;
        check_eq("gap_respack", bus_respack, 1'b0);
        @(negedge clk);
        #1;
      end
      bus_respcyc = 1'b1;
      bus_resp    = beat_data(line, k);
      if (k == rst_beat) begin
        do_reset(rst_entry);
        return;
      end
      if (k == redir_beat) begin
        redirect_valid = 1'b1;
        redirect_pc    = redir_to;
      end
      #1;
      check_eq("beat_respack", bus_respack, 1'b1);
      check_eq("fill_valid", out_valid, 1'b0);
      @(negedge clk);
      redirect_valid = 1'b0;
      bus_respcyc    = 1'b0;
      #1;
    end
    $display("txn fill line=%h", line);
    if (push) begin
      for (logic [63:0] a = start_pc; (a & ~64'h3F) == line; a += 64'd4) begin
        e.pc    = a;
        e.instr = exp_instr(a);
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic drain_n(input int n);
    exp_t e;
    for (int i = 0; i < n && sb_q.size() > 0; i++) begin
      e         = sb_q.pop_front();
      out_ready = 1'b1;
      check_eq("drain_valid", out_valid, 1'b1);
      check_eq("drain_pc", out_pc, e.pc);
      check_eq("drain_instr", out_instr, e.instr);
      $display("txn out pc=%h instr=%h", out_pc, out_instr);
      @(negedge clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset(64'h1000);

    // Full line from its start, then the next line is requested.
    do_req(64'h1000, 0);
    do_fill(64'h1000, 64'h1000, 1'b1, -1, 64'h0, -1, 64'h0);
    drain_n(16);
    check_eq("sb_empty_1", sb_q.size(), 0);

    // Slow ack, then a redirect mid-fill discards the line.
    do_req(64'h1040, 5);
    do_fill(64'h1040, 64'h0, 1'b0, 3, 64'h2004, -1, 64'h0);
    do_req(64'h2000, 0);
    do_fill(64'h2000, 64'h2004, 1'b1, -1, 64'h0, -1, 64'h0);
    drain_n(3);

    // Stall with out_ready low, then redirect with a same-cycle handshake.
    for (int i = 0; i < 4; i++) begin
      check_eq("stall_valid", out_valid, 1'b1);
      check_eq("stall_pc", out_pc, sb_q[0].pc);
      check_eq("stall_instr", out_instr, sb_q[0].instr);
      @(negedge clk);
      #1;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h4008;
    out_ready      = 1'b1;
    #1;
    check_eq("redir_valid", out_valid, 1'b1);
    @(negedge clk);
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    #1;
    check_eq("post_redir_valid", out_valid, 1'b0);
    sb_q.delete();

    // Reset lands on beat 5 of the redirect line's fill.
    do_req(64'h4000, 0);
    do_fill(64'h4000, 64'h0, 1'b0, -1, 64'h0, 5, 64'h3000);
    do_req(64'h3000, 0);
    do_fill(64'h3000, 64'h3000, 1'b1, -1, 64'h0, -1, 64'h0);
    drain_n(16);
    check_eq("next_req_cyc_3", bus_reqcyc, 1'b1);
    check_eq("next_req_3", bus_req, 64'h3040);

    // Entry near the end of a line: exactly two instructions.
    do_reset(64'h1038);
    do_req(64'h1000, 0);
    do_fill(64'h1000, 64'h1038, 1'b1, -1, 64'h0, -1, 64'h0);
    drain_n(16);
    check_eq("next_req_cyc_1", bus_reqcyc, 1'b1);
    check_eq("next_req_1", bus_req, 64'h1040);

    // pc wraps past the top of the address space.
    do_reset(64'hFFFF_FFFF_FFFF_FFF8);
    do_req(64'hFFFF_FFFF_FFFF_FFC0, 0);
    do_fill(64'hFFFF_FFFF_FFFF_FFC0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, -1, 64'h0, -1, 64'h0);
    drain_n(16);
    check_eq("wrap_req_cyc", bus_reqcyc, 1'b1);
    check_eq("wrap_req", bus_req, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
